// File: rtl/kinase_seq_pkg.sv
// Shared definitions for the kinase array sequencer: state encodings,
// per-state valve patterns and the peristaltic pump phase table.
package kinase_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MIX   = 3'd2,
        ST_INCUB = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Control valve patterns, bit 0 = c1; 1 = pressurised (closed).
    localparam logic [31:0] VLV_LOAD  = 32'h0000_1A35;
    localparam logic [31:0] VLV_MIX   = 32'h0000_0F0C;
    localparam logic [31:0] VLV_INCUB = 32'h0000_1FFF;
    localparam logic [31:0] VLV_FLUSH = 32'h0000_10C3;

    // Sieve valve patterns, bit 0 = s1; 1 = actuated.
    localparam logic [31:0] SV_LOAD  = 32'h0000_0003;
    localparam logic [31:0] SV_MIX   = 32'h0000_000F;
    localparam logic [31:0] SV_INCUB = 32'h0000_000F;
    localparam logic [31:0] SV_FLUSH = 32'h0000_0000;

    // Peristaltic sequence p1p2p3 = 110 -> 011 -> 101, returned with bit 0 = p1.
    function automatic logic [2:0] pump_phase_pattern(input logic [1:0] idx);
        logic [2:0] pat;
        case (idx)
            2'd0:    pat = 3'b011;
            2'd1:    pat = 3'b110;
            2'd2:    pat = 3'b101;
            default: pat = 3'b011;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/kinase_pump_phase.sv
// Pump phase generator: dwell divider feeding a 3-phase peristaltic rotator.
module kinase_pump_phase
    import kinase_seq_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic [2:0]       phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (restart) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (en) begin
            if (cnt_q == div) begin
                cnt_d = '0;
                idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign phase = pump_phase_pattern(idx_q);

endmodule

// File: rtl/kinase_array_sequencer.sv
// Valve/pump sequencer for an N-channel kinase assay array:
// LOAD -> MIX -> INCUB -> FLUSH -> DONE with per-channel isolation.
module kinase_array_sequencer
    import kinase_seq_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned N_VALVE = 13,
    parameter int unsigned N_SIEVE = 4,
    parameter int unsigned N_PUMP  = 5,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DIV_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_CH-1:0]    ch_en,
    input  logic [CNT_W-1:0]   load_cycles,
    input  logic [CNT_W-1:0]   mix_cycles,
    input  logic [CNT_W-1:0]   incub_cycles,
    input  logic [CNT_W-1:0]   flush_cycles,
    input  logic [DIV_W-1:0]   pump_div,
    output logic [N_VALVE-1:0] valve_c,
    output logic [N_SIEVE-1:0] valve_s,
    output logic [N_PUMP-1:0]  pump_p,
    output logic [N_CH-1:0]    ch_iso,
    output logic               busy,
    output logic               done,
    output logic               start_err,
    output logic [2:0]         state_o
);

    function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] x);
        return (x == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : x;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   mix_q, mix_d, incub_q, incub_d, flush_q, flush_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [N_CH-1:0]    ch_en_q, ch_en_d;
    logic [N_VALVE-1:0] valve_c_q, valve_c_d;
    logic [N_SIEVE-1:0] valve_s_q, valve_s_d;
    logic [N_CH-1:0]    ch_iso_q, ch_iso_d;
    logic               busy_q, busy_d, done_q, done_d, start_err_q, start_err_d;
    logic [2:0]         phase;
    logic               pump_restart, pump_en;

    // The LOAD duration goes straight into the step counter at start, so it needs no latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mix_d       = mix_q;
        incub_d     = incub_q;
        flush_d     = flush_q;
        div_d       = div_q;
        ch_en_d     = ch_en_q;
        start_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (ch_en != '0) begin
                        ch_en_d = ch_en;
                        mix_d   = mix_cycles;
                        incub_d = incub_cycles;
                        flush_d = flush_cycles;
                        div_d   = pump_div;
                        cnt_d   = nz(load_cycles);
                        state_d = ST_LOAD;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD, ST_MIX, ST_INCUB: begin
                if (abort) begin
                    state_d = ST_FLUSH;
                    cnt_d   = nz(flush_q);
                end else if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    case (state_q)
                        ST_LOAD: begin state_d = ST_MIX;   cnt_d = nz(mix_q);   end
                        ST_MIX:  begin state_d = ST_INCUB; cnt_d = nz(incub_q); end
                        default: begin state_d = ST_FLUSH; cnt_d = nz(flush_q); end
                    endcase
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FLUSH: begin
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_comb begin
        valve_c_d = '1;
        valve_s_d = '0;
        ch_iso_d  = '1;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        case (state_d)
            ST_LOAD: begin
                valve_c_d = N_VALVE'(VLV_LOAD);
                valve_s_d = N_SIEVE'(SV_LOAD);
                ch_iso_d  = ~ch_en_d;
            end
            ST_MIX: begin
                valve_c_d = N_VALVE'(VLV_MIX);
                valve_s_d = N_SIEVE'(SV_MIX);
                ch_iso_d  = ~ch_en_d;
            end
            ST_INCUB: begin
                valve_c_d = N_VALVE'(VLV_INCUB);
                valve_s_d = N_SIEVE'(SV_INCUB);
                ch_iso_d  = ~ch_en_d;
            end
            ST_FLUSH: begin
                valve_c_d = N_VALVE'(VLV_FLUSH);
                valve_s_d = N_SIEVE'(SV_FLUSH);
                ch_iso_d  = ~ch_en_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mix_q       <= '0;
            incub_q     <= '0;
            flush_q     <= '0;
            div_q       <= '0;
            ch_en_q     <= '0;
            valve_c_q   <= '1;
            valve_s_q   <= '0;
            ch_iso_q    <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mix_q       <= mix_d;
            incub_q     <= incub_d;
            flush_q     <= flush_d;
            div_q       <= div_d;
            ch_en_q     <= ch_en_d;
            valve_c_q   <= valve_c_d;
            valve_s_q   <= valve_s_d;
            ch_iso_q    <= ch_iso_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
        end
    end

    assign pump_restart = (state_d == ST_MIX) && (state_q != ST_MIX);
    assign pump_en      = (state_q == ST_MIX);

    kinase_pump_phase #(
        .DIV_W(DIV_W)
    ) u_pump_phase (
        .clk     (clk),
        .rst     (rst),
        .en      (pump_en),
        .restart (pump_restart),
        .div     (div_q),
        .phase   (phase)
    );

    // Pump lines decode the registered state and phase register directly.
    always_comb begin
        pump_p = '1;
        case (state_q)
            ST_LOAD: pump_p = '0;
            ST_MIX:  pump_p[2:0] = phase;
            default: ;
        endcase
    end

    assign valve_c   = valve_c_q;
    assign valve_s   = valve_s_q;
    assign ch_iso    = ch_iso_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign start_err = start_err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_kinase_array_sequencer.sv
// Scoreboard bench for kinase_array_sequencer: table of runs expanded into
// per-cycle expected outputs, plus hand sequences for reset and start errors.
module tb_kinase_array_sequencer;
    import kinase_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [1:0]  ch_en;
    logic [15:0] load_cycles, mix_cycles, incub_cycles, flush_cycles;
    logic [7:0]  pump_div;
    logic [12:0] valve_c;
    logic [3:0]  valve_s;
    logic [4:0]  pump_p;
    logic [1:0]  ch_iso;
    logic        busy, done, start_err;
    logic [2:0]  state_o;

    kinase_array_sequencer #(
        .N_CH(2), .N_VALVE(13), .N_SIEVE(4), .N_PUMP(5), .CNT_W(16), .DIV_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_en(ch_en),
        .load_cycles(load_cycles), .mix_cycles(mix_cycles),
        .incub_cycles(incub_cycles), .flush_cycles(flush_cycles),
        .pump_div(pump_div), .valve_c(valve_c), .valve_s(valve_s),
        .pump_p(pump_p), .ch_iso(ch_iso), .busy(busy), .done(done),
        .start_err(start_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        busy;
        logic        done;
        logic        serr;
        logic [4:0]  pump;
        logic [1:0]  iso;
        logic [12:0] vc;
        logic [3:0]  vs;
    } obs_t;

    typedef struct {
        logic [1:0] ch_en;
        int         load, mix, incub, flush, div;
        int         abort_at;
        int         rst_at;
        bit         start_abort;
        bit         hold_start;
    } row_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int nz(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    // Expected outputs for a given state; c is the cycle index within MIX.
    function automatic obs_t mk(input int s, input int c, input row_t r);
        obs_t o;
        logic [2:0] seq [3];
        logic [2:0] pat;
        seq = '{3'b110, 3'b011, 3'b101};
        o.st   = 3'(s);
        o.busy = (s != 0);
        o.done = (s == 5);
        o.serr = 1'b0;
        o.iso  = (s >= 1 && s <= 4) ? ~r.ch_en : 2'b11;
        o.pump = 5'b11111;
        o.vc   = 13'h1FFF;
        o.vs   = 4'h0;
        case (s)
            1: begin o.pump = 5'b00000; o.vc = 13'(VLV_LOAD); o.vs = 4'(SV_LOAD); end
            2: begin
                pat = seq[(c / (r.div + 1)) % 3];
                o.pump = {2'b11, pat[0], pat[1], pat[2]};
                o.vc = 13'(VLV_MIX); o.vs = 4'(SV_MIX);
            end
            3: begin o.vc = 13'(VLV_INCUB); o.vs = 4'(SV_INCUB); end
            4: begin o.vc = 13'(VLV_FLUSH); o.vs = 4'(SV_FLUSH); end
            default: ;
        endcase
        return o;
    endfunction

    task automatic build(input row_t r);
        int lens [3];
        int idx  = 0;
        int stop = 0;
        lens = '{nz(r.load), nz(r.mix), nz(r.incub)};
        for (int s = 0; s < 3 && stop == 0; s++)
            for (int c = 0; c < lens[s] && stop == 0; c++) begin
                exp_q.push_back(mk(s + 1, c, r));
                if (idx == r.rst_at) stop = 2;
                else if (idx == r.abort_at) stop = 1;
                idx++;
            end
        if (stop != 2)
            for (int c = 0; c < nz(r.flush) && stop != 2; c++) begin
                exp_q.push_back(mk(4, 0, r));
                if (idx == r.rst_at) stop = 2;
                idx++;
            end
        if (stop != 2) exp_q.push_back(mk(5, 0, r));
        exp_q.push_back(mk(0, 0, r));
    endtask

    task automatic check(input string name, input int cyc);
        obs_t got, e;
        got = {state_o, busy, done, start_err, pump_p, ch_iso, valve_c, valve_s};
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s cyc%0d: scoreboard empty, got %h", name, cyc, got);
            return;
        end
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got st=%0d busy=%b done=%b serr=%b pump=%b iso=%b vc=%h vs=%h, want st=%0d busy=%b done=%b serr=%b pump=%b iso=%b vc=%h vs=%h",
                     name, cyc, got.st, got.busy, got.done, got.serr, got.pump, got.iso, got.vc, got.vs,
                     e.st, e.busy, e.done, e.serr, e.pump, e.iso, e.vc, e.vs);
        end
    endtask

    task automatic run_row(input int ri, input row_t r);
        int n;
        string nm;
        nm = $sformatf("row%0d", ri);
        build(r);
        n = exp_q.size();
        @(posedge clk); #1;
        start = 1'b1; abort = r.start_abort; ch_en = r.ch_en;
        load_cycles = 16'(r.load); mix_cycles = 16'(r.mix);
        incub_cycles = 16'(r.incub); flush_cycles = 16'(r.flush);
        pump_div = 8'(r.div);
        @(posedge clk); #1;
        start = r.hold_start; abort = 1'b0; ch_en = ~r.ch_en;
        load_cycles = 16'd1; mix_cycles = 16'd1; incub_cycles = 16'd1;
        flush_cycles = 16'd1; pump_div = 8'd3;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(nm, i);
            abort = (i == r.abort_at);
            rst   = (i == r.rst_at);
            start = r.hold_start && (i < n - 3);
        end
        abort = 1'b0; rst = 1'b0; start = 1'b0;
    endtask

    row_t rows [8];
    obs_t idle_o;

    initial begin
        row_t z;
        z = '{ch_en: 2'b11, load: 0, mix: 0, incub: 0, flush: 0, div: 0,
              abort_at: -1, rst_at: -1, start_abort: 1'b0, hold_start: 1'b0};
        rows[0] = '{2'b11, 3, 6, 4, 2, 0, -1, -1, 1'b0, 1'b1};
        rows[1] = '{2'b11, 1, 12, 1, 1, 1, -1, -1, 1'b1, 1'b0};
        rows[2] = '{2'b11, 2, 3, 4, 5, 0, 6, -1, 1'b0, 1'b0};
        rows[3] = '{2'b01, 2, 2, 2, 3, 2, 7, -1, 1'b0, 1'b0};
        rows[4] = '{2'b10, 0, 0, 0, 0, 0, -1, -1, 1'b0, 1'b0};
        rows[5] = '{2'b01, 2, 5, 1, 1, 0, 0, -1, 1'b0, 1'b0};
        rows[6] = '{2'b11, 2, 10, 3, 3, 0, -1, 4, 1'b0, 1'b0};
        rows[7] = '{2'b01, 0, 4, 1, 1, 1, -1, -1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; ch_en = 2'b00;
        load_cycles = '0; mix_cycles = '0; incub_cycles = '0; flush_cycles = '0;
        pump_div = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_o = mk(0, 0, z);
        exp_q.push_back(idle_o);
        @(negedge clk);
        check("reset", 0);

        // Rejected start: one start_err pulse, outputs otherwise idle.
        @(posedge clk); #1;
        start = 1'b1; ch_en = 2'b00; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        idle_o.serr = 1'b1;
        exp_q.push_back(idle_o);
        idle_o.serr = 1'b0;
        exp_q.push_back(idle_o);
        exp_q.push_back(idle_o);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("start_err", i);
        end

        for (int r = 0; r < 8; r++) run_row(r, rows[r]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
